ctrl_seq_unit: RTL and testbench

Parametrised successor of the processor's fixed-rhythm control unit. It sequences the fetch/decode/register-read/ALU/memory/write-back stage enables as a multi-cycle FSM with:
- a ready handshake to memory,
- a configurable multi-cycle ALU stage,
- a skippable memory stage,
- halt/resume and a watchdog timeout.

Sits between the core datapath blocks (reg file, decoder, ALU, PC unit, RAM) and drives their enable inputs.

---
 rtl/ctrl_seq_unit.sv | 170 +++++++++++++++++
 tb/tb_ctrl_seq_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer: FETCH/DEC/RD/ALU/MEM/WB stage enables with memory
// handshake, watchdog and halt/resume. Define CTRL_SEQ_PERF_EN to build the stall counter.
module ctrl_seq_unit #(
  parameter int ALU_CYCLES = 1,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic             needs_mem,
  input  logic             halt_req,
  input  logic             resume,
  output logic             enfetch,
  output logic             endec,
  output logic             enrgrd,
  output logic             enalu,
  output logic             enmem,
  output logic             update,
  output logic [2:0]       state,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [15:0]      stall_count
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_DEC   = 3'd1,
    ST_RD    = 3'd2,
    ST_ALU   = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  localparam int ALU_W  = 3;
  localparam int WAIT_W = 8;
  localparam logic [ALU_W-1:0]  ALU_LAST  = ALU_W'(ALU_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  if (ALU_CYCLES < 1 || ALU_CYCLES > 8) begin : g_bad_alu_cycles
    $error("ctrl_seq_unit: ALU_CYCLES must be in 1..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ctrl_seq_unit: TIMEOUT must be in 2..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("ctrl_seq_unit: CNT_W must be at least 1");
  end

  state_t             state_reg, state_next;
  logic [2:0]         state_next_code;
  logic               run_reg;
  logic [ALU_W-1:0]   alu_cnt_reg, alu_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               timeout_err_reg, timeout_err_next;
  logic [CNT_W-1:0]   instr_cnt_reg, instr_cnt_next;
  logic [5:0]         en_reg, en_next;
  logic               halted_reg;

  // run_reg is low for the first edge after reset release so that edge lands in FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_FETCH;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    alu_cnt_next     = alu_cnt_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg;
    instr_cnt_next   = instr_cnt_reg;
    if (run_reg) begin
      unique case (state_reg)
        ST_FETCH, ST_MEM: begin
          if (mem_ready) begin
            wait_cnt_next = '0;
            state_next    = (state_reg == ST_FETCH) ? ST_DEC : ST_WB;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_next    = '0;
            timeout_err_next = 1'b1;
            state_next       = ST_HALT;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end
        ST_DEC: state_next = ST_RD;
        ST_RD:  state_next = ST_ALU;
        ST_ALU: begin
          if (alu_cnt_reg == ALU_LAST) begin
            alu_cnt_next = '0;
            state_next   = needs_mem ? ST_MEM : ST_WB;
          end else begin
            alu_cnt_next = alu_cnt_reg + ALU_W'(1);
          end
        end
        ST_WB: begin
          instr_cnt_next = instr_cnt_reg + CNT_W'(1);
          state_next     = halt_req ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          if (resume) state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
    end
  end

  // Enables are registered from the next state so they line up with the state output.
  assign state_next_code = state_next;
  for (genvar gi = 0; gi < 6; gi++) begin : g_en
    assign en_next[gi] = (state_next_code == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_cnt_reg     <= '0;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      instr_cnt_reg   <= '0;
      en_reg          <= '0;
      halted_reg      <= 1'b0;
    end else begin
      alu_cnt_reg     <= alu_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
      instr_cnt_reg   <= instr_cnt_next;
      en_reg          <= en_next;
      halted_reg      <= (state_next == ST_HALT);
    end
  end

`ifdef CTRL_SEQ_PERF_EN
  logic        stalled;
  logic [15:0] stall_cnt_reg;

  assign stalled = run_reg && !mem_ready &&
                   ((state_reg == ST_FETCH) || (state_reg == ST_MEM));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stalled && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_count = stall_cnt_reg;
`else
  assign stall_count = 16'h0000;
`endif

  assign enfetch     = en_reg[0];
  assign endec       = en_reg[1];
  assign enrgrd      = en_reg[2];
  assign enalu       = en_reg[3];
  assign enmem       = en_reg[4];
  assign update      = en_reg[5];
  assign state       = state_reg;
  assign halted      = halted_reg;
  assign timeout_err = timeout_err_reg;
  assign instr_count = instr_cnt_reg;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Bench for ctrl_seq_unit (ALU_CYCLES=3, TIMEOUT=4): per-cycle vector table checked through
// a scoreboard queue, then instruction-latency measurements.
module tb_ctrl_seq_unit;

  localparam int ALU_CYC = 3;
  localparam int TMO     = 4;
  localparam int CW      = 16;
`ifdef CTRL_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] EZ = 6'b000000;
  localparam logic [5:0] EF = 6'b000001;
  localparam logic [5:0] ED = 6'b000010;
  localparam logic [5:0] ER = 6'b000100;
  localparam logic [5:0] EA = 6'b001000;
  localparam logic [5:0] EM = 6'b010000;
  localparam logic [5:0] EW = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, mem_ready, needs_mem, halt_req, resume;
  logic enfetch, endec, enrgrd, enalu, enmem, update;
  logic [2:0] state;
  logic halted, timeout_err;
  logic [CW-1:0] instr_count;
  logic [15:0] stall_count;

  ctrl_seq_unit #(.ALU_CYCLES(ALU_CYC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .needs_mem(needs_mem),
    .halt_req(halt_req), .resume(resume), .enfetch(enfetch), .endec(endec),
    .enrgrd(enrgrd), .enalu(enalu), .enmem(enmem), .update(update), .state(state),
    .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count),
    .stall_count(stall_count)
  );

  typedef struct {
    logic       rst_n, mr, nm, hr, rs;
    logic [2:0] st;
    logic [5:0] en;
    logic       hl, te;
    int         ic, sc;
  } vec_t;

  typedef struct {
    int         row;
    logic [2:0] st;
    logic [5:0] en;
    logic       hl, te;
    int         ic, sc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst_n, mr, nm, hr, rs, input logic [2:0] st,
                     input logic [5:0] en, input logic hl, te, input int ic, sc);
    vec_t v;
    v.rst_n = rst_n; v.mr = mr; v.nm = nm; v.hr = hr; v.rs = rs;
    v.st = st; v.en = en; v.hl = hl; v.te = te; v.ic = ic; v.sc = sc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h required %0h", name, row, act, req);
    end
  endtask

  // Scoreboard: compare the oldest pending expectation just after each active edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state", e.row, 32'(state), 32'(e.st));
      chk("enables", e.row, 32'({update, enmem, enalu, enrgrd, endec, enfetch}), 32'(e.en));
      chk("halted", e.row, 32'(halted), 32'(e.hl));
      chk("timeout_err", e.row, 32'(timeout_err), 32'(e.te));
      chk("instr_count", e.row, 32'(instr_count), 32'(e.ic));
      chk("stall_count", e.row, 32'(stall_count), PERF ? 32'(e.sc) : 32'd0);
      $display("row %0d: state=%0d en=%b halted=%b terr=%b icount=%0d stall=%0d",
               e.row, state, {update, enmem, enalu, enrgrd, endec, enfetch},
               halted, timeout_err, instr_count, stall_count);
    end
  end

  // Cycles from one enfetch cycle to the next for an instruction with the given needs_mem.
  task automatic measure(input logic nm, input int req, input string name);
    int cyc;
    needs_mem = nm; mem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    while (!enfetch && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!enfetch && cyc < 40);
    chk(name, -1, 32'(cyc), 32'(req));
    $display("latency needs_mem=%b: %0d cycles", nm, cyc);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t e;
    reset = 1'b0; mem_ready = 1'b0; needs_mem = 1'b0; halt_req = 1'b0; resume = 1'b0;

    // rst_n mr nm hr rs | state en halted terr icount stall
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, EZ, 0, 0, 0, 0);
    // straight-line, ignored mem_ready/halt_req/resume outside their states
    add(1, 1, 0, 0, 0, 0, EF, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, ED, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 2, ER, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 3, EA, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 3, EA, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 3, EA, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 5, EW, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, EF, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, ED, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 2, ER, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 3, EA, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 5, EW, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, EF, 0, 0, 2, 0);
    // memory instruction, needs_mem only matters in the last ALU cycle, 3 stalls in MEM
    add(1, 1, 1, 0, 0, 1, ED, 0, 0, 2, 0);
    add(1, 1, 1, 0, 0, 2, ER, 0, 0, 2, 0);
    add(1, 1, 0, 0, 0, 3, EA, 0, 0, 2, 0);
    add(1, 1, 0, 0, 0, 3, EA, 0, 0, 2, 0);
    add(1, 1, 1, 0, 0, 3, EA, 0, 0, 2, 0);
    add(1, 1, 1, 0, 0, 4, EM, 0, 0, 2, 0);
    add(1, 0, 1, 0, 0, 4, EM, 0, 0, 2, 1);
    add(1, 0, 1, 0, 0, 4, EM, 0, 0, 2, 2);
    add(1, 0, 1, 0, 0, 4, EM, 0, 0, 2, 3);
    add(1, 1, 1, 0, 0, 5, EW, 0, 0, 2, 3);
    add(1, 1, 0, 0, 0, 0, EF, 0, 0, 3, 3);
    // halt in WB, held 10 cycles, then resume
    add(1, 1, 0, 0, 0, 1, ED, 0, 0, 3, 3);
    add(1, 1, 0, 0, 0, 2, ER, 0, 0, 3, 3);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 3, EA, 0, 0, 3, 3);
    add(1, 1, 0, 0, 0, 5, EW, 0, 0, 3, 3);
    add(1, 1, 0, 1, 0, 6, EZ, 1, 0, 4, 3);
    for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 6, EZ, 1, 0, 4, 3);
    add(1, 1, 0, 0, 1, 0, EF, 0, 0, 4, 3);
    // watchdog in FETCH
    add(1, 0, 0, 0, 0, 0, EF, 0, 0, 4, 4);
    add(1, 0, 0, 0, 0, 0, EF, 0, 0, 4, 5);
    add(1, 0, 0, 0, 0, 0, EF, 0, 0, 4, 6);
    add(1, 0, 0, 0, 0, 6, EZ, 1, 1, 4, 7);
    add(1, 0, 0, 0, 0, 6, EZ, 1, 1, 4, 7);
    add(1, 0, 0, 0, 1, 0, EF, 0, 1, 4, 7);
    // reset while waiting in MEM
    add(1, 1, 1, 0, 0, 1, ED, 0, 1, 4, 7);
    add(1, 1, 1, 0, 0, 2, ER, 0, 1, 4, 7);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 3, EA, 0, 1, 4, 7);
    add(1, 1, 1, 0, 0, 4, EM, 0, 1, 4, 7);
    add(1, 0, 1, 0, 0, 4, EM, 0, 1, 4, 8);
    add(0, 0, 1, 0, 0, 0, EZ, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, EZ, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, EF, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, ED, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst_n; mem_ready = tbl[i].mr; needs_mem = tbl[i].nm;
      halt_req = tbl[i].hr; resume = tbl[i].rs;
      e.row = i; e.st = tbl[i].st; e.en = tbl[i].en; e.hl = tbl[i].hl;
      e.te = tbl[i].te; e.ic = tbl[i].ic; e.sc = tbl[i].sc;
      sb.push_back(e);
    end
    @(posedge clk); #2;
    chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);

    measure(1'b0, 4 + ALU_CYC, "latency_no_mem");
    measure(1'b1, 5 + ALU_CYC, "latency_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
